stream_out_framer: RTL and testbench

- Sits directly downstream of the BRAM stream interface wrapper's 128-bit output stream and feeds the DMA MM2S/S2MM-side AXI-Stream.
- Frames a result transfer of a programmed byte length into DMA bursts of BURST_BEATS beats, with tlast on each burst end and tkeep trimmed on the final beat.
- Checks the upstream tlast against the programmed length and reports mismatches.
- Provides a registered, full-throughput output through a 2-entry skid buffer.

---
 rtl/stream_out_framer.sv | 184 ++++++++++++++++++
 tb/tb_stream_out_framer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_framer.sv
// stream_out_framer: frames a byte-length result transfer from a 128-bit upstream stream into
// BURST_BEATS-beat AXI-Stream bursts, trims tkeep on the final beat, checks upstream tlast
// against the programmed length, and drives the output from a 2-entry skid buffer.
module stream_out_framer #(
    parameter int unsigned BURST_BEATS = 16,
    parameter int unsigned DATA_W      = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cfg_len_bytes,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [15:0]       m_tkeep,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic              err_early_last,
    output logic              err_missing_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [7:0] BURST_LAST = 8'(BURST_BEATS - 1);
    localparam int unsigned ENT_W = DATA_W + 17;

    // Beat count needs 29 bits: ceil((2^32-1)/16) is 2^28.
    logic [1:0]       state_q, state_d;
    logic [28:0]      beats_total_q, beats_total_d;
    logic [28:0]      beat_cnt_q, beat_cnt_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [15:0]      last_keep_q, last_keep_d;
    logic             done_q, done_d;
    logic             err_early_q, err_early_d;
    logic             err_miss_q, err_miss_d;

    // Skid entries are packed as {last, keep, data}; head_q drives the output directly.
    logic [1:0]       occ_q, occ_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;

    logic             cfg_hs, push, pop;
    logic             cnt_final, in_final, in_last;
    logic [15:0]      in_keep;
    logic [ENT_W-1:0] in_ent;

    assign cfg_ready = rst_n & (state_q == ST_IDLE);
    assign s_tready  = rst_n & (state_q == ST_RUN) & (occ_q != 2'd2);
    assign m_tvalid  = (occ_q != 2'd0);
    assign m_tdata   = head_q[DATA_W-1:0];
    assign m_tkeep   = head_q[DATA_W+15:DATA_W];
    assign m_tlast   = head_q[ENT_W-1];
    assign busy      = (state_q != ST_IDLE) | (occ_q != 2'd0);
    assign done             = done_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_miss_q;

    assign cfg_hs    = cfg_valid & cfg_ready;
    assign push      = s_tvalid & s_tready;
    assign pop       = m_tvalid & m_tready;
    assign cnt_final = (beat_cnt_q == beats_total_q - 29'd1);
    assign in_final  = cnt_final | s_tlast;
    assign in_last   = in_final | (burst_cnt_q == BURST_LAST);
    // An early-tlast beat is a full beat; only the counted final beat is trimmed.
    assign in_keep   = cnt_final ? last_keep_q : 16'hffff;
    assign in_ent    = {in_last, in_keep, s_tdata};

    // Framing FSM: latch config, count beats/bursts, flag tlast mismatches, signal completion.
    always_comb begin
        state_d       = state_q;
        beats_total_d = beats_total_q;
        beat_cnt_d    = beat_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        last_keep_d   = last_keep_q;
        done_d        = 1'b0;
        err_early_d   = 1'b0;
        err_miss_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    beats_total_d = {1'b0, cfg_len_bytes[31:4]} + 29'(|cfg_len_bytes[3:0]);
                    last_keep_d   = (cfg_len_bytes[3:0] == 4'd0) ? 16'hffff
                                  : (16'h1 << cfg_len_bytes[3:0]) - 16'h1;
                    beat_cnt_d    = '0;
                    burst_cnt_d   = '0;
                    if (cfg_len_bytes == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (push) begin
                    beat_cnt_d  = beat_cnt_q + 29'd1;
                    burst_cnt_d = in_last ? 8'd0 : burst_cnt_q + 8'd1;
                    err_early_d = s_tlast & ~cnt_final;
                    err_miss_d  = cnt_final & ~s_tlast;
                    if (in_final) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Nothing is pushed here, so popping the only entry retires the final beat.
                if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skid buffer: head is the registered output, tail catches one beat under backpressure.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = in_ent;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_ent;
                end else if (push) begin
                    tail_d = in_ent;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beats_total_q <= '0;
            beat_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            last_keep_q   <= '0;
            done_q        <= 1'b0;
            err_early_q   <= 1'b0;
            err_miss_q    <= 1'b0;
            occ_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            beats_total_q <= beats_total_d;
            beat_cnt_q    <= beat_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            last_keep_q   <= last_keep_d;
            done_q        <= done_d;
            err_early_q   <= err_early_d;
            err_miss_q    <= err_miss_d;
            occ_q         <= occ_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

endmodule

// File: tb/tb_stream_out_framer.sv
// Directed self-checking bench for stream_out_framer (BURST_BEATS=16).
module tb_stream_out_framer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  cfg_len_bytes = '0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         busy;
    logic         done;
    logic         err_early_last;
    logic         err_missing_last;

    always #5 clk = ~clk;

    stream_out_framer #(
        .BURST_BEATS(16),
        .DATA_W     (128)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_len_bytes   (cfg_len_bytes),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tlast         (s_tlast),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tkeep         (m_tkeep),
        .m_tlast         (m_tlast),
        .busy            (busy),
        .done            (done),
        .err_early_last  (err_early_last),
        .err_missing_last(err_missing_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int tag, input int idx);
        logic [15:0] t;
        logic [15:0] n;
        t = tag[15:0];
        n = idx[15:0];
        return {4{t, n}};
    endfunction

    // Downstream ready: 0 = always ready, 1 = toggle, 2 = never ready.
    int rmode = 0;
    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor on the falling edge: records handshakes about to happen and tracks skid occupancy.
    int           cyc = 0;
    logic [127:0] out_data[$];
    logic [16:0]  out_kl[$];
    int           pop_cyc[$];
    int           push_cyc[$];
    int           done_cnt = 0, early_cnt = 0, miss_cnt = 0, busy_cnt = 0, done_cyc = 0;
    int           occ = 0, full_seen = 0, stable_err = 0, sready_err = 0, valid_err = 0;
    logic         stall_q = 1'b0;
    logic [145:0] stall_val = '0;
    logic         bp_watch = 1'b0;
    int           bp_limit = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            occ     = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q && ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== stall_val)) stable_err++;
            if (m_tvalid !== (occ != 0)) valid_err++;
            if (occ == 2) full_seen++;
            if (bp_watch && s_tvalid && !s_tready && occ < 2 && push_cyc.size() < bp_limit)
                sready_err++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_early_last) early_cnt++;
            if (err_missing_last) miss_cnt++;
            if (busy) busy_cnt++;
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_kl.push_back({m_tkeep, m_tlast});
                pop_cyc.push_back(cyc);
                occ--;
            end
            if (s_tvalid && s_tready) begin
                push_cyc.push_back(cyc);
                occ++;
            end
            stall_q   = m_tvalid && !m_tready;
            stall_val = {m_tvalid, m_tdata, m_tkeep, m_tlast};
        end
    end

    task automatic do_cfg(input logic [31:0] len);
        int   w;
        logic hs;
        w = 0;
        cfg_len_bytes = len;
        cfg_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = cfg_ready;
            @(posedge clk);
            #1;
            w++;
        end while (!hs && w < 100);
        cfg_valid = 1'b0;
        check_eq("cfg_accept", 128'(hs), 128'(1));
    endtask

    // Sends beats first..first+n-1; s_tlast on the beat whose 1-based index equals last_at.
    task automatic send(input int tag, input int first, input int n, input int last_at);
        int   w;
        logic hs;
        for (int i = first; i < first + n; i++) begin
            w = 0;
            s_tvalid = 1'b1;
            s_tdata  = pat(tag, i);
            s_tlast  = (i + 1 == last_at);
            do begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk);
                #1;
                w++;
            end while (!hs && w < 100);
            if (!hs) check_eq("s_accept", 128'(hs), 128'(1));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int w;
        w = 0;
        while (done_cnt == base && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq(tag, 128'(done_cnt - base), 128'(1));
    endtask

    task automatic expect_beat(input string tag, input int idx, input logic [127:0] d,
                               input logic [15:0] k, input logic l);
        if (idx >= out_data.size()) begin
            check_eq({tag, "_present"}, 128'(out_data.size()), 128'(idx + 1));
        end else begin
            check_eq({tag, "_data"}, out_data[idx], d);
            check_eq({tag, "_keep_last"}, 128'(out_kl[idx]), 128'({k, l}));
        end
    endtask

    int b, pb, d0, e0, m0, bz;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cfg_ready", 128'(cfg_ready), 128'(0));
        check_eq("rst_s_tready", 128'(s_tready), 128'(0));
        check_eq("rst_m_out", {m_tvalid, m_tdata[126:0]}, 128'(0));
        check_eq("rst_keep_last", 128'({m_tkeep, m_tlast}), 128'(0));
        check_eq("rst_flags", 128'({busy, done, err_early_last, err_missing_last}), 128'(0));
        rst_n = 1'b1;
        #1;
        check_eq("idle_cfg_ready", 128'(cfg_ready), 128'(1));

        // len=40: 3 beats, tkeep trimmed to 00ff on the last
        rmode = 0;
        @(posedge clk);
        #1;
        b = out_data.size(); pb = push_cyc.size(); d0 = done_cnt; e0 = early_cnt; m0 = miss_cnt;
        do_cfg(32'd40);
        send(1, 0, 3, 3);
        wait_done("s1_done", d0);
        check_eq("s1_count", 128'(out_data.size() - b), 128'(3));
        expect_beat("s1_b0", b, pat(1, 0), 16'hffff, 1'b0);
        expect_beat("s1_b1", b + 1, pat(1, 1), 16'hffff, 1'b0);
        expect_beat("s1_b2", b + 2, pat(1, 2), 16'h00ff, 1'b1);
        check_eq("s1_latency", 128'(pop_cyc[b] - push_cyc[pb]), 128'(1));
        check_eq("s1_done_time", 128'(done_cyc - pop_cyc[b + 2]), 128'(1));
        check_eq("s1_errs", 128'((early_cnt - e0) + (miss_cnt - m0)), 128'(0));

        // len=560: 35 beats, bursts of 16
        b = out_data.size(); d0 = done_cnt;
        do_cfg(32'd560);
        send(2, 0, 35, 35);
        wait_done("s2_done", d0);
        check_eq("s2_count", 128'(out_data.size() - b), 128'(35));
        for (int i = 0; i < 35; i++) begin
            expect_beat($sformatf("s2_b%0d", i), b + i, pat(2, i), 16'hffff,
                        (i == 15) || (i == 31) || (i == 34));
        end
        check_eq("s2_throughput", 128'(pop_cyc[b + 34] - pop_cyc[b]), 128'(34));

        // Backpressure: toggling m_tready with continuous s_tvalid, 10 beats
        b = out_data.size(); d0 = done_cnt;
        do_cfg(32'd160);
        bp_limit = push_cyc.size() + 10;
        bp_watch = 1'b1;
        rmode = 1;
        send(3, 0, 10, 10);
        wait_done("s3_done", d0);
        bp_watch = 1'b0;
        rmode = 0;
        check_eq("s3_count", 128'(out_data.size() - b), 128'(10));
        for (int i = 0; i < 10; i++) begin
            expect_beat($sformatf("s3_b%0d", i), b + i, pat(3, i), 16'hffff, i == 9);
        end
        check_eq("s3_full_seen", 128'(full_seen > 0), 128'(1));
        check_eq("s3_s_tready_drop", 128'(sready_err), 128'(0));

        // Early tlast: len=64, tlast on beat 2
        b = out_data.size(); d0 = done_cnt; e0 = early_cnt; m0 = miss_cnt;
        do_cfg(32'd64);
        send(4, 0, 2, 2);
        wait_done("s4_done", d0);
        check_eq("s4_count", 128'(out_data.size() - b), 128'(2));
        expect_beat("s4_b0", b, pat(4, 0), 16'hffff, 1'b0);
        expect_beat("s4_b1", b + 1, pat(4, 1), 16'hffff, 1'b1);
        check_eq("s4_early", 128'(early_cnt - e0), 128'(1));
        check_eq("s4_missing", 128'(miss_cnt - m0), 128'(0));
        check_eq("s4_idle", 128'(cfg_ready), 128'(1));

        // Missing tlast: len=32, no s_tlast
        b = out_data.size(); d0 = done_cnt; e0 = early_cnt; m0 = miss_cnt;
        do_cfg(32'd32);
        send(5, 0, 2, 0);
        s_tvalid = 1'b1;
        s_tdata  = pat(5, 2);
        @(negedge clk);
        check_eq("s5_stall_after", 128'(s_tready), 128'(0));
        wait_done("s5_done", d0);
        @(negedge clk);
        check_eq("s5_stall_idle", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check_eq("s5_count", 128'(out_data.size() - b), 128'(2));
        expect_beat("s5_b1", b + 1, pat(5, 1), 16'hffff, 1'b1);
        check_eq("s5_missing", 128'(miss_cnt - m0), 128'(1));
        check_eq("s5_early", 128'(early_cnt - e0), 128'(0));

        // Zero length
        b = out_data.size(); d0 = done_cnt; bz = busy_cnt;
        do_cfg(32'd0);
        wait_done("s6_done", d0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("s6_no_beats", 128'(out_data.size() - b), 128'(0));
        check_eq("s6_not_busy", 128'(busy_cnt - bz), 128'(0));

        // Reset mid-transfer with downstream stalled
        do_cfg(32'd160);
        send(7, 0, 4, 0);
        rmode = 2;
        send(7, 4, 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("s7_rst_valid", 128'(m_tvalid), 128'(0));
        check_eq("s7_rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        #1;
        check_eq("s7_idle_ready", 128'(cfg_ready), 128'(1));
        rmode = 0;
        b = out_data.size(); d0 = done_cnt;
        do_cfg(32'd16);
        send(8, 0, 1, 1);
        wait_done("s7_done", d0);
        check_eq("s7_count", 128'(out_data.size() - b), 128'(1));
        expect_beat("s7_b0", b, pat(8, 0), 16'hffff, 1'b1);

        check_eq("hold_stable", 128'(stable_err), 128'(0));
        check_eq("valid_vs_occupancy", 128'(valid_err), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
